// File: rtl/srm_controller.sv
// srm_controller: multi-cycle FSM sequencing decode, operand fetch, execute and writeback for a small ALU/MOV ISA
module srm_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8
);
  localparam logic [2:0] WAIT = 3'd0, DECODE = 3'd1, GET_A = 3'd2, GET_B = 3'd3,
                         EXEC = 3'd4, WR_REG = 3'd5, WR_IMM = 3'd6;
  logic [2:0] state, next;
  logic [15:0] ir;
  logic wr, la, lb, lc, ls, ill;
  wire [2:0] opcode = ir[15:13];
  wire [1:0] op = ir[12:11];
  wire [2:0] rn = ir[10:8];
  wire [2:0] rd = ir[7:5];
  wire [1:0] sh = ir[4:3];
  wire [2:0] rm = ir[2:0];
  wire is_movi = opcode == 3'b110 && op == 2'b10;
  wire is_movr = opcode == 3'b110 && op == 2'b00;
  wire is_alu = opcode == 3'b101;
  wire is_cmp = is_alu && op == 2'b01;
  wire is_mvn = is_alu && op == 2'b11;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT;
      ir <= 16'd0;
    end else begin
      state <= next;
      if (state == WAIT && s) ir <= instr;
    end
  end
  always_comb begin
    next = WAIT;
    wr = 1'b0;
    la = 1'b0;
    lb = 1'b0;
    lc = 1'b0;
    ls = 1'b0;
    ill = 1'b0;
    asel = 1'b0;
    vsel = 2'b00;
    shift = 2'b00;
    ALUop = 2'b00;
    readnum = 3'd0;
    writenum = 3'd0;
    case (state)
      WAIT: next = s ? DECODE : WAIT;
      DECODE: begin
        next = is_movi ? WR_IMM : (is_movr || is_mvn) ? GET_B : is_alu ? GET_A : WAIT;
        ill = !(is_movi || is_movr || is_alu);
      end
      GET_A: begin
        readnum = rn;
        la = 1'b1;
        next = GET_B;
      end
      GET_B: begin
        readnum = rm;
        lb = 1'b1;
        next = EXEC;
      end
      EXEC: begin
        shift = sh;
        ALUop = is_movr ? 2'b00 : op;
        asel = is_movr;
        ls = is_cmp;
        lc = !is_cmp;
        next = is_cmp ? WAIT : WR_REG;
      end
      WR_REG: begin
        writenum = rd;
        wr = 1'b1;
      end
      WR_IMM: begin
        writenum = rn;
        vsel = 2'b10;
        wr = 1'b1;
      end
      default: next = WAIT;
    endcase
  end
  // strobes are masked during reset so an aborted instruction cannot write or load
  assign write = wr & ~reset;
  assign loada = la & ~reset;
  assign loadb = lb & ~reset;
  assign loadc = lc & ~reset;
  assign loads = ls & ~reset;
  assign illegal = ill & ~reset;
  assign bsel = 1'b0;
  assign w = state == WAIT;
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
endmodule

// File: tb/tb_srm_controller.sv
// tb_srm_controller: scoreboard bench; stimulus queues expected per-cycle outputs, a negedge monitor compares them
module tb_srm_controller;
  logic clk = 1'b0, reset, s;
  logic [15:0] instr;
  logic w, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0] readnum, writenum;
  logic [1:0] vsel, shift, ALUop;
  logic [15:0] sximm8;
  int tests = 0, fails = 0, writes = 0, illegals = 0;
  logic [2:0] last_wn;
  logic [15:0] last_sx;
  logic [35:0] exp_q[$];

  srm_controller dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w), .illegal(illegal),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .vsel(vsel), .shift(shift), .ALUop(ALUop), .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] vec(input logic il, input logic [2:0] rdn, input logic [2:0] wn,
      input logic wr, input logic la, input logic lb, input logic lc, input logic ls,
      input logic as, input logic [1:0] vs, input logic [1:0] sh, input logic [1:0] al,
      input logic [15:0] sx);
    return {il, rdn, wn, wr, la, lb, lc, ls, as, 1'b0, vs, sh, al, sx};
  endfunction

  // expected output vector for every non-WAIT cycle of one instruction, truncated to n cycles
  task automatic push_model(input logic [15:0] i, input int n);
    logic [35:0] seq[$];
    logic [15:0] sx = {{8{i[7]}}, i[7:0]};
    logic [1:0] op = i[12:11];
    logic mov_i = i[15:13] == 3'b110 && op == 2'b10;
    logic mov_r = i[15:13] == 3'b110 && op == 2'b00;
    logic alu = i[15:13] == 3'b101;
    logic cmp = alu && op == 2'b01;
    logic legal = mov_i || mov_r || alu;
    seq.push_back(vec(!legal, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, sx));
    if (mov_i)
      seq.push_back(vec(0, 0, i[10:8], 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, sx));
    else if (legal) begin
      if (alu && op != 2'b11)
        seq.push_back(vec(0, i[10:8], 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, sx));
      seq.push_back(vec(0, i[2:0], 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, sx));
      seq.push_back(vec(0, 0, 0, 0, 0, 0, !cmp, cmp, mov_r, 2'b00, i[4:3], alu ? op : 2'b00, sx));
      if (!cmp) seq.push_back(vec(0, 0, i[7:5], 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, sx));
    end
    for (int k = 0; k < n && k < seq.size(); k++) exp_q.push_back(seq[k]);
  endtask

  always @(negedge clk) begin
    if (write) begin
      writes++;
      last_wn = writenum;
      last_sx = sximm8;
    end
    if (illegal) illegals++;
    if (!w) begin
      if (exp_q.size() == 0) chk("unexpected_busy", 36'd1, 36'd0);
      else chk("cycle_outputs", {illegal, readnum, writenum, write, loada, loadb, loadc, loads,
                                 asel, bsel, vsel, shift, ALUop, sximm8}, exp_q.pop_front());
    end else
      chk("idle_strobes", {30'd0, write, loada, loadb, loadc, loads, illegal}, 36'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!w && n < 50) begin
      tick;
      n++;
    end
    chk({name, "_idle"}, {35'd0, w}, 36'd1);
    chk({name, "_drained"}, 36'(exp_q.size()), 36'd0);
  endtask

  task automatic issue(input logic [15:0] i);
    instr = i;
    s = 1'b1;
    push_model(i, 99);
    tick;
    s = 1'b0;
    instr = 16'($urandom);
  endtask

  logic [15:0] list[6] = '{16'hD107, 16'hB14A, 16'hB874, 16'hAD06, 16'hE000, 16'hC081};
  int wb, ib;

  initial begin
    reset = 1'b1;
    s = 1'b0;
    instr = 16'h0;
    tick;
    tick;
    chk("reset_w", {35'd0, w}, 36'd1);
    chk("reset_sximm8", {20'd0, sximm8}, 36'd0);
    s = 1'b1;
    instr = 16'hD3FE;
    tick;
    chk("reset_dominates_s", {35'd0, w}, 36'd1);
    chk("reset_ir_held", {20'd0, sximm8}, 36'd0);
    reset = 1'b0;
    wb = writes;
    push_model(16'hD3FE, 99);
    tick;
    s = 1'b0;
    instr = 16'h1234;
    wait_idle("mov_imm");
    chk("mov_imm_writes", 36'(writes - wb), 36'd1);
    chk("mov_imm_wn", {33'd0, last_wn}, 36'd3);
    chk("mov_imm_sx", {20'd0, last_sx}, 36'h0FFFE);
    wb = writes;
    issue(16'hA148);
    wait_idle("add");
    chk("add_writes", 36'(writes - wb), 36'd1);
    chk("add_wn", {33'd0, last_wn}, 36'd2);
    wb = writes;
    issue(16'hAD06);
    wait_idle("cmp");
    chk("cmp_writes", 36'(writes - wb), 36'd0);
    wb = writes;
    ib = illegals;
    issue(16'hE000);
    wait_idle("illegal");
    chk("illegal_pulses", 36'(illegals - ib), 36'd1);
    chk("illegal_writes", 36'(writes - wb), 36'd0);
    wb = writes;
    instr = 16'hA148;
    s = 1'b1;
    push_model(16'hA148, 2);
    tick;
    s = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    exp_q.push_back(vec(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 16'h0048));
    tick;
    reset = 1'b0;
    chk("abort_to_wait", {35'd0, w}, 36'd1);
    chk("abort_ir_cleared", {20'd0, sximm8}, 36'd0);
    chk("abort_no_write", 36'(writes - wb), 36'd0);
    issue(16'hD005);
    wait_idle("after_abort");
    chk("after_abort_writes", 36'(writes - wb), 36'd1);
    chk("after_abort_wn", {33'd0, last_wn}, 36'd0);
    chk("after_abort_sx", {20'd0, last_sx}, 36'd5);
    wb = writes;
    ib = illegals;
    begin
      int k = 0, cyc = 0;
      s = 1'b1;
      while (k < 6 && cyc < 300) begin
        if (w) begin
          instr = list[k];
          push_model(list[k], 99);
          k++;
        end else
          instr = 16'($urandom);
        tick;
        cyc++;
      end
      s = 1'b0;
      chk("stream_accepted", 36'(k), 36'd6);
    end
    wait_idle("stream");
    chk("stream_writes", 36'(writes - wb), 36'd4);
    chk("stream_illegals", 36'(illegals - ib), 36'd1);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
